// File: rtl/sync_chain.sv
// Multi-bit flip-flop synchroniser: STAGES registers per channel, no other logic.
// Generalises the classic two-stage synchroniser and is usable on its own.
module sync_chain #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] sync_out
);

    logic [WIDTH-1:0] stage_q [STAGES];
    logic [WIDTH-1:0] stage_d [STAGES];

    // Each stage takes the value of the one before it; stage 0 takes the raw pins.
    always_comb begin
        stage_d[0] = async_in;
        for (int k = 1; k < STAGES; k++) begin
            stage_d[k] = stage_q[k-1];
        end
    end

    // Chain registers, cleared together on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                stage_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                stage_q[k] <= stage_d[k];
            end
        end
    end

    assign sync_out = stage_q[STAGES-1];

endmodule

// File: rtl/io_conditioner.sv
// Multi-channel input conditioner: synchronise, then symmetrically debounce
// each channel on a shared sample pulse, producing level plus edge strobes.
module io_conditioner #(
    parameter int WIDTH          = 1,
    parameter int SYNC_STAGES    = 2,
    parameter int SAMPLE_CNT_MAX = 25000,
    parameter int PULSE_CNT_MAX  = 150
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    // A timer of MAX 1 still needs one bit even though it never leaves 0.
    localparam int SAMPLE_W = (SAMPLE_CNT_MAX > 1) ? $clog2(SAMPLE_CNT_MAX) : 1;
    localparam int PULSE_W  = $clog2(PULSE_CNT_MAX + 1);
    localparam logic [SAMPLE_W-1:0] SAMPLE_LAST = SAMPLE_W'(SAMPLE_CNT_MAX - 1);
    localparam logic [PULSE_W-1:0]  PULSE_LAST  = PULSE_W'(PULSE_CNT_MAX - 1);

    logic [WIDTH-1:0]    s;
    logic [SAMPLE_W-1:0] timer_q;
    logic [SAMPLE_W-1:0] timer_d;
    logic                sample;

    sync_chain #(
        .WIDTH  (WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (async_in),
        .sync_out (s)
    );

    assign sample = (timer_q == SAMPLE_LAST);

    // Shared timebase: count up and wrap to 0 on the sample cycle.
    always_comb begin
        timer_d = timer_q + SAMPLE_W'(1);
        if (sample) begin
            timer_d = '0;
        end
    end

    // Sample timer register.
    always_ff @(posedge clk) begin
        if (rst) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end

    for (genvar ch = 0; ch < WIDTH; ch++) begin : g_chan
        logic [PULSE_W-1:0] cnt_q;
        logic [PULSE_W-1:0] cnt_d;
        logic               level_q;
        logic               level_d;
        logic               rise_q;
        logic               rise_d;
        logic               fall_q;
        logic               fall_d;

        // Count consecutive disagreeing samples; any agreeing sample clears
        // the count, and the last needed disagreement flips the level.
        always_comb begin
            cnt_d   = cnt_q;
            level_d = level_q;
            rise_d  = 1'b0;
            fall_d  = 1'b0;
            if (sample) begin
                if (s[ch] == level_q) begin
                    cnt_d = '0;
                end else if (cnt_q == PULSE_LAST) begin
                    level_d = s[ch];
                    cnt_d   = '0;
                    rise_d  = s[ch];
                    fall_d  = ~s[ch];
                end else begin
                    cnt_d = cnt_q + PULSE_W'(1);
                end
            end
        end

        // Per-channel debounce state and strobes, registered together so the
        // strobe lines up with the new level.
        always_ff @(posedge clk) begin
            if (rst) begin
                cnt_q   <= '0;
                level_q <= 1'b0;
                rise_q  <= 1'b0;
                fall_q  <= 1'b0;
            end else begin
                cnt_q   <= cnt_d;
                level_q <= level_d;
                rise_q  <= rise_d;
                fall_q  <= fall_d;
            end
        end

        assign level[ch] = level_q;
        assign rise[ch]  = rise_q;
        assign fall[ch]  = fall_q;
    end

endmodule
